// File: rtl/c2c_interval_timer_if.sv
// Bundle of the per-channel timer controls and status for the c2c interval timer.
// The controller side (master) drives start/mode (and pause when TIMER_PAUSE_EN
// is defined); the timer side (slave) returns done/expired/busy.
interface c2c_interval_timer_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] mode;
`ifdef TIMER_PAUSE_EN
  logic [NUM_CH-1:0] pause;
`endif
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] expired;
  logic [NUM_CH-1:0] busy;

`ifdef TIMER_PAUSE_EN
  modport master (output start, output mode, output pause,
                  input done, input expired, input busy);
  modport slave  (input start, input mode, input pause,
                  output done, output expired, output busy);
`else
  modport master (output start, output mode,
                  input done, input expired, input busy);
  modport slave  (input start, input mode,
                  output done, output expired, output busy);
`endif
endinterface

// File: rtl/c2c_interval_timer.sv
// Multi-channel interval timer for the chip2chip link (LED blink, heartbeat,
// handshake timeouts). Each channel counts TERMINAL cycles while start is held,
// either once (one-shot, then holds expired) or repeatedly (periodic).
// Optional macro TIMER_PAUSE_EN adds a per-channel pause input that freezes
// the count while in RUN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | channel stopped, count cleared, waiting for start
// RUN     | counting; done pulses when count reaches TERMINAL-1
// EXPIRED | one-shot has fired; held until start drops
module c2c_interval_timer #(
  parameter int          CNT_WIDTH = 27,
  parameter int unsigned TERMINAL  = 100000000,
  parameter int          NUM_CH    = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  c2c_interval_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  // Last count value of an interval; the compare happens on this value so the
  // done pulse lands exactly TERMINAL edges after the start edge.
  localparam logic [CNT_WIDTH-1:0] TC = CNT_WIDTH'(TERMINAL - 1);

  logic [NUM_CH-1:0] done_vec;
  logic [NUM_CH-1:0] expired_vec;
  logic [NUM_CH-1:0] busy_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t               state;
    logic [CNT_WIDTH-1:0] count;
    logic                 mode_q;
    logic                 done_q;
    logic                 expired_q;
    logic                 busy_q;
    logic                 pause_i;

`ifdef TIMER_PAUSE_EN
    assign pause_i = bus.pause[i];
`else
    assign pause_i = 1'b0;
`endif

    // Per-channel sequencer: state, count, latched mode and registered status.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state     <= IDLE;
        count     <= '0;
        mode_q    <= 1'b0;
        done_q    <= 1'b0;
        expired_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        done_q <= 1'b0;
        case (state)
          IDLE: begin
            count <= '0;
            if (bus.start[i]) begin
              state  <= RUN;
              mode_q <= bus.mode[i];
              busy_q <= 1'b1;
            end
          end
          RUN: begin
            // Dropping start wins over an expiry on the same edge.
            if (!bus.start[i]) begin
              state  <= IDLE;
              count  <= '0;
              busy_q <= 1'b0;
            end else if (pause_i) begin
              count <= count;
            end else if (count == TC) begin
              done_q <= 1'b1;
              count  <= '0;
              if (!mode_q) begin
                state     <= EXPIRED;
                busy_q    <= 1'b0;
                expired_q <= 1'b1;
              end
            end else begin
              count <= count + CNT_WIDTH'(1);
            end
          end
          EXPIRED: begin
            count <= '0;
            if (!bus.start[i]) begin
              state     <= IDLE;
              expired_q <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            count     <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
          end
        endcase
      end
    end

    assign done_vec[i]    = done_q;
    assign expired_vec[i] = expired_q;
    assign busy_vec[i]    = busy_q;
  end

  assign bus.done    = done_vec;
  assign bus.expired = expired_vec;
  assign bus.busy    = busy_vec;

endmodule
